// File: rtl/cpu_pkg.sv
// Shared register-file constants and the writeback entry layout used by the
// write buffer and its lookup logic.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbuf_match.sv
// Youngest-match search over the valid window of the write buffer.
// Returns hit and the data of the entry closest to the tail with reg==query.
module wbuf_match
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic [ADDR_W-1:0]        ent_reg  [DEPTH],
    input  logic [DATA_W-1:0]        ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_W-1:0]        query,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (query != ADDR_W'(REG_ZERO)) &&
                (ent_reg[idx] == query)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Circular buffer of pending register writebacks drained one per cycle into
// the register file write port, with two youngest-value hazard lookup ports.
module regfile_write_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_reg,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   drain_en,
    output logic                   WrEn,
    output logic [ADDR_W-1:0]      WrReg,
    output logic [DATA_W-1:0]      WrData,
    input  logic [ADDR_W-1:0]      RdReg1,
    input  logic [ADDR_W-1:0]      RdReg2,
    output logic                   pend1,
    output logic                   pend2,
    output logic [DATA_W-1:0]      fwd1,
    output logic [DATA_W-1:0]      fwd2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              push;
    logic              pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    // A reset cycle must not commit anything to the register file.
    assign WrEn   = rst && !empty && drain_en;
    assign WrReg  = empty ? '0 : reg_q[rd_ptr_q];
    assign WrData = empty ? '0 : data_q[rd_ptr_q];

    // Writes to r0 complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_reg != ADDR_W'(REG_ZERO));
    assign pop  = WrEn;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        reg_d    = reg_q;
        data_d   = data_q;
        if (push) begin
            reg_d[wr_ptr_q]  = in_reg;
            data_d[wr_ptr_q] = in_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        reg_q  <= reg_d;
        data_q <= data_d;
    end

    wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
        .ent_reg  (reg_q),
        .ent_data (data_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .query    (RdReg1),
        .hit      (pend1),
        .data     (fwd1)
    );

    wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
        .ent_reg  (reg_q),
        .ent_data (data_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .query    (RdReg2),
        .hit      (pend2),
        .data     (fwd2)
    );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench: a queue model of pending writes is updated at each rising
// edge; a monitor on the falling edge compares every DUT output against it.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          WrEn;
    logic [AW-1:0] WrReg;
    logic [DW-1:0] WrData;
    logic [AW-1:0] RdReg1, RdReg2;
    logic          pend1, pend2;
    logic [DW-1:0] fwd1, fwd2;
    logic [$clog2(DEPTH):0] count;
    logic          full, empty;

    int   compared   = 0;
    int   mismatched = 0;
    bit   check_en   = 1'b0;
    ent_t mq[$];

    regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_reg   (in_reg),
        .in_data  (in_data),
        .drain_en (drain_en),
        .WrEn     (WrEn),
        .WrReg    (WrReg),
        .WrData   (WrData),
        .RdReg1   (RdReg1),
        .RdReg2   (RdReg2),
        .pend1    (pend1),
        .pend2    (pend2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Youngest pending value for a register, searched from the tail backward.
    task automatic model_lookup(input logic [AW-1:0] q, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (q != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].r == q) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                    break;
                end
            end
        end
    endtask

    // Reference model: commit happens on the rising edge using pre-edge state.
    initial begin
        ent_t e;
        bit   do_pop, do_push;
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
            end else begin
                do_pop  = drain_en && (mq.size() > 0);
                do_push = in_valid && (mq.size() < DEPTH) && (in_reg != 0);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.r = in_reg;
                    e.d = in_data;
                    mq.push_back(e);
                end
            end
        end
    end

    // Monitor: sample all outputs mid-cycle, away from the active edge.
    initial begin
        bit            h;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("wr_en", WrEn, rst && drain_en && (mq.size() > 0));
                if (mq.size() > 0) begin
                    chk("wr_reg", WrReg, mq[0].r);
                    chk("wr_data", WrData, mq[0].d);
                end else begin
                    chk("wr_reg_idle", WrReg, 0);
                    chk("wr_data_idle", WrData, 0);
                end
                chk("count", count, mq.size());
                chk("full", full, mq.size() == DEPTH);
                chk("empty", empty, mq.size() == 0);
                chk("in_ready", in_ready, mq.size() != DEPTH);
                model_lookup(RdReg1, h, d);
                chk("pend1", pend1, h);
                chk("fwd1", fwd1, d);
                model_lookup(RdReg2, h, d);
                chk("pend2", pend2, h);
                chk("fwd2", fwd2, d);
            end
        end
    end

    task automatic step(input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input bit de, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit rs);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        drain_en = de;
        RdReg1   = a1;
        RdReg2   = a2;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dp;
        rst = 1'b0; in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h1;
        drain_en = 1'b0; RdReg1 = '0; RdReg2 = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        step(1, 5, 32'h1, 1, 5, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // single write drained the next cycle
        step(1, 5, 32'hDEADBEEF, 1, 5, 0, 1);
        step(0, 0, 0, 1, 5, 0, 1);
        step(0, 0, 0, 1, 5, 0, 1);

        // fill with the port stalled, attempt a fifth push, then drain
        for (int i = 1; i <= 4; i++) step(1, AW'(i), DW'(i * 32'h11), 0, 2, 4, 1);
        step(1, 9, 32'h99, 0, 9, 3, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 3, 4, 1);

        // duplicate destinations, youngest forwarded, r0 never pending
        step(1, 7, 32'hA, 0, 7, 0, 1);
        step(1, 7, 32'hB, 0, 7, 0, 1);
        step(0, 0, 0, 0, 7, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 7, 0, 1);

        // r0 push is accepted but dropped
        step(1, 0, 32'hFF, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // steady state at count 2 with pointers wrapping
        step(1, 3, 32'h300, 0, 3, 6, 1);
        step(1, 6, 32'h600, 0, 3, 6, 1);
        for (int i = 0; i < 4; i++) step(1, AW'(10 + i), DW'(32'hC00 + i), 1, AW'(10 + i), 6, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 12, 13, 1);

        // reset with three entries queued and the port open
        for (int i = 0; i < 3; i++) step(1, AW'(20 + i), DW'(32'hE0 + i), 0, 21, 22, 1);
        step(0, 0, 0, 1, 21, 22, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 21, 22, 1);

        // randomized traffic with varying drain pressure
        dp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) dp = $urandom_range(10, 95);
            step($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < dp), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), ($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
